// File: rtl/usart_pkg.sv
// Definitions shared by the USART transmitter and receiver: FSM state names,
// parity mode encodings and the bit-period calculation.
package usart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } usart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Integer floor; any fractional remainder becomes a small baud error.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/usart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick on
// the last count of each period. A synchronous clear holds it at zero.
module usart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usart_tx.sv
// USART transmitter: one-entry holding register in front of a start/data/
// parity/stop serialiser, so a waiting word follows the previous stop bit.
module usart_tx
  import usart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic PAR_INV = (PARITY == PARITY_ODD);
  localparam logic HAS_PAR = (PARITY != PARITY_NONE);
  localparam logic TWO_STOP = (STOP_BITS == 2);

  if (CPB < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY < 0 || PARITY > 2) begin : g_cfg_check
    $error("usart_tx: illegal parameter combination");
  end

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] word);
    return (^word) ^ PAR_INV;
  endfunction

  usart_state_e           state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   hold_full_q, hold_full_d;
  logic                   accept, drain, tick, last_stop;

  usart_baud_gen #(
    .CLKS_PER_BIT(CPB)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q != ST_IDLE),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (tick)
  );

  assign accept    = tx_valid && !hold_full_q;
  assign last_stop = TWO_STOP ? stop_q : 1'b1;
  assign tx_ready  = !hold_full_q;
  assign busy      = (state_q != ST_IDLE);
  assign tx        = tx_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;
    drain   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          state_d = ST_START;
          shift_d = hold_q;
          par_d   = frame_parity(hold_q);
          tx_d    = 1'b0;
          drain   = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      // bit_q is the index of the data bit currently on the line
      ST_DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            stop_d  = 1'b0;
            state_d = HAS_PAR ? ST_PARITY : ST_STOP;
            tx_d    = HAS_PAR ? par_q : 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (last_stop) begin
            done = 1'b1;
            if (hold_full_q) begin
              state_d = ST_START;
              shift_d = hold_q;
              par_d   = frame_parity(hold_q);
              tx_d    = 1'b0;
              drain   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // A drain and a new accept in the same cycle leave the register full.
  always_comb begin
    hold_full_d = (hold_full_q && !drain) || accept;
    hold_d      = accept ? tx_data : hold_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      tx_q        <= 1'b1;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      tx_q        <= tx_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_usart_tx.sv
// Directed bench for usart_tx at 10 clocks per bit across four frame formats:
// 8N1, 8O1, 8E1 and 7N2.
module tb_usart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [8:0] data    [4];
  logic       valid   [4];
  logic       tx_w    [4];
  logic       ready_w [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  int checks = 0;
  int failures = 0;

  logic tr_tx[$];
  logic tr_done[$];
  logic tr_rdy[$];
  logic tr_busy[$];

  usart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) u0 (
    .clk(clk), .reset(reset), .tx_data(data[0][7:0]), .tx_valid(valid[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  usart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .tx_data(data[1][7:0]), .tx_valid(valid[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  usart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) u2 (
    .clk(clk), .reset(reset), .tx_data(data[2][7:0]), .tx_valid(valid[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  usart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .STOP_BITS(2), .PARITY(0)) u3 (
    .clk(clk), .reset(reset), .tx_data(data[3][6:0]), .tx_valid(valid[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic capture(input int u, input int n);
    repeat (n) begin
      @(negedge clk);
      tr_tx.push_back(tx_w[u]);
      tr_done.push_back(done_w[u]);
      tr_rdy.push_back(ready_w[u]);
      tr_busy.push_back(busy_w[u]);
    end
  endtask

  task automatic clear_trace();
    tr_tx.delete();
    tr_done.delete();
    tr_rdy.delete();
    tr_busy.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int u = 0; u < 4; u++) begin
      valid[u] = 1'b0;
      data[u]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
        checks++;
        if (tx_w[u] !== 1'b1 || ready_w[u] !== 1'b1 || busy_w[u] !== 1'b0 || done_w[u] !== 1'b0) begin
          failures++;
          $display("FAIL reset_idle u%0d cycle %0d: tx=%b ready=%b busy=%b done=%b, required tx=1 ready=1 busy=0 done=0",
                   u, c, tx_w[u], ready_w[u], busy_w[u], done_w[u]);
        end
      end
    end
  endtask

  // frame holds the line bits in send order (bit 0 = start); nbits counts bit periods.
  task automatic test_frame(input int u, input logic [8:0] word, input logic [11:0] frame,
                            input int nbits, input string name);
    int bad, dcnt, didx;
    @(negedge clk);
    valid[u] = 1'b1;
    data[u]  = word;
    @(posedge clk);
    #1;
    valid[u] = 1'b0;
    data[u]  = ~word;
    clear_trace();
    capture(u, nbits * 10 + 20);

    checks++;
    if (tr_tx[0] !== 1'b1 || tr_rdy[0] !== 1'b0 || tr_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL %s accepted: tx=%b ready=%b busy=%b, required tx=1 ready=0 busy=0",
               name, tr_tx[0], tr_rdy[0], tr_busy[0]);
    end
    checks++;
    if (tr_tx[1] !== 1'b0 || tr_rdy[1] !== 1'b1 || tr_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL %s start_entry: tx=%b ready=%b busy=%b, required tx=0 ready=1 busy=1",
               name, tr_tx[1], tr_rdy[1], tr_busy[1]);
    end
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      for (int s = 0; s < 10; s++)
        if (tr_tx[1 + 10 * b + s] !== frame[b]) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL %s line_bit%0d: %0d of 10 samples differ (mid sample %b), required %b",
                 name, b, bad, tr_tx[1 + 10 * b + 5], frame[b]);
      end
    end
    dcnt = 0;
    didx = -1;
    foreach (tr_done[i])
      if (tr_done[i] === 1'b1) begin
        dcnt++;
        didx = i;
      end
    checks++;
    if (dcnt != 1 || didx != nbits * 10) begin
      failures++;
      $display("FAIL %s done_pulse: count=%0d at sample %0d, required count=1 at sample %0d",
               name, dcnt, didx, nbits * 10);
    end
    bad = 0;
    for (int i = nbits * 10 + 1; i < nbits * 10 + 20; i++)
      if (tr_tx[i] !== 1'b1 || tr_busy[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s idle_after: %0d bad samples, required tx=1 busy=0 throughout", name, bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic [7:0] got;
    int acc, s, dcnt, bad;
    logic r, v, prev;
    words[0] = 8'h55;
    words[1] = 8'hFF;
    words[2] = 8'h00;
    acc = 0;
    prev = 1'b0;
    clear_trace();
    fork
      begin
        for (int c = 0; c < 400; c++) begin
          @(negedge clk);
          if (prev) begin
            checks++;
            if (ready_w[0] !== 1'b0) begin
              failures++;
              $display("FAIL stream ready_drop after accept %0d: ready=%b, required 0", acc, ready_w[0]);
            end
          end
          valid[0] = (acc < 3);
          if (acc < 3) data[0] = {1'b0, words[acc]};
          r = ready_w[0];
          v = valid[0];
          @(posedge clk);
          prev = v && r;
          if (prev) acc++;
        end
        valid[0] = 1'b0;
      end
      capture(0, 400);
    join

    checks++;
    if (acc != 3) begin
      failures++;
      $display("FAIL stream accepts: got %0d, required 3", acc);
    end
    s = -1;
    for (int i = 0; i < 50; i++)
      if (s < 0 && tr_tx[i] === 1'b0) s = i;
    checks++;
    if (s < 0) begin
      failures++;
      $display("FAIL stream first_start: no start bit within 50 cycles, required one");
      s = 0;
    end
    for (int k = 0; k < 3; k++) begin
      got = '0;
      for (int b = 0; b < 8; b++) got[b] = tr_tx[s + 100 * k + 10 * (b + 1) + 5];
      checks++;
      if (got !== words[k]) begin
        failures++;
        $display("FAIL stream word%0d: received %h, required %h", k, got, words[k]);
      end
      checks++;
      if (tr_tx[s + 100 * k] !== 1'b0 || tr_tx[s + 100 * k + 9] !== 1'b0 ||
          tr_tx[s + 100 * k + 95] !== 1'b1) begin
        failures++;
        $display("FAIL stream framing%0d: start=%b/%b stop=%b, required start=0/0 stop=1", k,
                 tr_tx[s + 100 * k], tr_tx[s + 100 * k + 9], tr_tx[s + 100 * k + 95]);
      end
      checks++;
      if (tr_done[s + 100 * k + 99] !== 1'b1) begin
        failures++;
        $display("FAIL stream done%0d: done=%b in last stop cycle, required 1", k, tr_done[s + 100 * k + 99]);
      end
    end
    dcnt = 0;
    foreach (tr_done[i]) if (tr_done[i] === 1'b1) dcnt++;
    bad = 0;
    for (int i = s + 300; i < 400; i++) if (tr_tx[i] !== 1'b1) bad++;
    checks++;
    if (dcnt != 3 || bad != 0) begin
      failures++;
      $display("FAIL stream tail: done_count=%0d low_after=%0d, required done_count=3 low_after=0", dcnt, bad);
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 9'h0A5;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 9'h03C;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    repeat (43) @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b0 || ready_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid pre: tx=%b ready=%b busy=%b, required tx=0 ready=0 busy=1",
               tx_w[0], ready_w[0], busy_w[0]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1 || ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid async: tx=%b ready=%b busy=%b done=%b, required tx=1 ready=1 busy=0 done=0",
               tx_w[0], ready_w[0], busy_w[0], done_w[0]);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || done_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || ready_w[0] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_mid after: %0d bad cycles, required tx=1 done=0 busy=0 ready=1 throughout", bad);
    end
  endtask

  initial begin
    test_reset();
    test_frame(0, 9'h0A5, {1'b1, 8'hA5, 1'b0}, 10, "a5_8n1");
    test_frame(1, 9'h003, {1'b1, 1'b1, 8'h03, 1'b0}, 11, "03_8o1");
    test_frame(2, 9'h003, {1'b1, 1'b0, 8'h03, 1'b0}, 11, "03_8e1");
    test_frame(3, 9'h07F, {2'b11, 7'h7F, 1'b0}, 10, "7f_7n2");
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
